// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types and defaults for the FFT frame sequencer: FSM state encoding,
// frame geometry and AXI-stream beat width.
`default_nettype none

package fft_pkg;

  localparam int          FFT_FRAME_LEN = 512;
  localparam int          FFT_IDX_W     = $clog2(FFT_FRAME_LEN);
  localparam int          AXI_BEAT_W    = 32;
  localparam logic [15:0] CFG_WORD_DEF  = 16'h0001;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CONFIG      = 2'd1,
    FILL        = 2'd2,
    WAIT_RESULT = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fft_frame_sequencer_sample_hold_reg.sv
// One-entry valid/ready holding register between the sample strobe and the
// FFT input stream, with a sticky overrun flag for samples that find it full.
`default_nettype none

module sample_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             overrun_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overrun_q, overrun_d;
  logic             drain;
  logic             take;

  always_comb begin
    drain     = valid_q & ready_i;
    take      = load_en_i & valid_i;
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (drain) begin
      valid_d = 1'b0;
    end
    // A slot freed by this cycle's handshake can be refilled in the same cycle.
    if (take) begin
      if (!valid_q || drain) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign overrun_o = overrun_q;

endmodule

`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
// Configures the FFT core once per enable, frames decimated samples into
// AXI-stream beats and holds off each new frame until the FFT result drains.
`default_nettype none

module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int                   FRAME_LEN    = FFT_FRAME_LEN,
  parameter int                   SAMPLE_WIDTH = 8,
  parameter int                   CFG_WIDTH    = 16,
  parameter logic [CFG_WIDTH-1:0] CFG_WORD     = CFG_WIDTH'(CFG_WORD_DEF)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  output logic [CFG_WIDTH-1:0]    cfg_tdata_out,
  output logic                    cfg_tvalid_out,
  input  logic                    cfg_tready_in,
  output logic [AXI_BEAT_W-1:0]   data_tdata_out,
  output logic                    data_tvalid_out,
  output logic                    data_tlast_out,
  input  logic                    data_tready_in,
  input  logic                    result_last_in,
  input  logic                    result_hs_in,
  output logic                    busy_out,
  output logic                    overrun_out,
  output logic [15:0]             frame_count_out
);

  localparam int             IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic                    hold_valid;
  logic [SAMPLE_WIDTH-1:0] hold_data;
  logic                    hold_overrun;
  logic                    beat_hs;
  logic                    last_hs;
  logic                    load_en;

  assign beat_hs = hold_valid & data_tready_in;
  assign last_hs = beat_hs & (idx_q == LAST_IDX);
  // A sample coinciding with the final beat handshake belongs to the inter-frame gap.
  assign load_en = (state_q == FILL) & ~last_hs;

  sample_hold_reg #(
    .WIDTH (SAMPLE_WIDTH)
  ) u_hold (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .load_en_i (load_en),
    .valid_i   (sample_valid_in),
    .data_i    (sample_in),
    .ready_i   (data_tready_in),
    .valid_o   (hold_valid),
    .data_o    (hold_data),
    .overrun_o (hold_overrun)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable_in) state_d = CONFIG;
      end
      CONFIG: begin
        if (cfg_tready_in) state_d = FILL;
      end
      FILL: begin
        if (last_hs) state_d = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (result_hs_in && result_last_in) state_d = enable_in ? FILL : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_out       = (state_q != IDLE);
    cfg_tvalid_out = (state_q == CONFIG);
  end

  always_comb begin
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    if (beat_hs) begin
      idx_d = idx_q + 1'b1;
    end
    if (last_hs) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idx_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign cfg_tdata_out   = CFG_WORD;
  assign data_tdata_out  = AXI_BEAT_W'(hold_data) << (AXI_BEAT_W - SAMPLE_WIDTH);
  assign data_tvalid_out = hold_valid;
  assign data_tlast_out  = hold_valid & (idx_q == LAST_IDX);
  assign overrun_out     = hold_overrun;
  assign frame_count_out = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer: directed strobes push expected
// beats, a negedge monitor pops and compares each beat handshake.
`default_nettype none

module tb_fft_frame_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        enable_in;
  logic [7:0]  sample_in;
  logic        sample_valid_in;
  logic [15:0] cfg_tdata_out;
  logic        cfg_tvalid_out;
  logic        cfg_tready_in;
  logic [31:0] data_tdata_out;
  logic        data_tvalid_out;
  logic        data_tlast_out;
  logic        data_tready_in;
  logic        result_last_in;
  logic        result_hs_in;
  logic        busy_out;
  logic        overrun_out;
  logic [15:0] frame_count_out;

  fft_frame_sequencer dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .cfg_tdata_out   (cfg_tdata_out),
    .cfg_tvalid_out  (cfg_tvalid_out),
    .cfg_tready_in   (cfg_tready_in),
    .data_tdata_out  (data_tdata_out),
    .data_tvalid_out (data_tvalid_out),
    .data_tlast_out  (data_tlast_out),
    .data_tready_in  (data_tready_in),
    .result_last_in  (result_last_in),
    .result_hs_in    (result_hs_in),
    .busy_out        (busy_out),
    .overrun_out     (overrun_out),
    .frame_count_out (frame_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          exp_idx     = 0;
  int          checks      = 0;
  int          failures    = 0;
  int          beats_seen  = 0;
  int          lasts_seen  = 0;
  int          cfg_hs_seen = 0;
  logic        prev_stall  = 1'b0;
  logic [31:0] prev_data   = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every value here is sampled mid-cycle, ahead of the edge that acts on it.
  always @(negedge clk_in) begin
    beat_t e;
    if (rst_in) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_stable", {31'd0, data_tvalid_out}, 32'd1);
        chk("stall_data_stable", data_tdata_out, prev_data);
      end
      if (cfg_tvalid_out && cfg_tready_in) cfg_hs_seen++;
      if (data_tvalid_out && data_tready_in) begin
        beats_seen++;
        if (data_tlast_out) lasts_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected: got data 0x%0h last %0b, expected no beat", data_tdata_out, data_tlast_out);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", data_tdata_out, e.data);
          chk("beat_last", {31'd0, data_tlast_out}, {31'd0, e.last});
        end
      end
      prev_stall = data_tvalid_out && !data_tready_in;
      prev_data  = data_tdata_out;
    end
  end

  function automatic logic [7:0] sv(input int k, input int seed);
    return 8'((k * 37 + seed) & 255);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_beat(input logic [7:0] s);
    beat_t b;
    b.data = {s, 24'h0};
    b.last = (exp_idx == 511);
    exp_q.push_back(b);
    exp_idx = (exp_idx == 511) ? 0 : exp_idx + 1;
  endtask

  task automatic strobe(input logic [7:0] s, input bit accept);
    if (accept) push_beat(s);
    sample_in       = s;
    sample_valid_in = 1'b1;
    tick();
    sample_valid_in = 1'b0;
  endtask

  task automatic drain_wait(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic result_done();
    result_hs_in   = 1'b1;
    result_last_in = 1'b1;
    tick();
    result_hs_in   = 1'b0;
    result_last_in = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cfg_cycles;
    rst_in          = 1'b1;
    enable_in       = 1'b0;
    sample_in       = '0;
    sample_valid_in = 1'b0;
    cfg_tready_in   = 1'b0;
    data_tready_in  = 1'b0;
    result_last_in  = 1'b0;
    result_hs_in    = 1'b0;
    repeat (3) tick();
    rst_in = 1'b0;
    tick();

    chk("rst_cfg_tdata", {16'd0, cfg_tdata_out}, 32'h0001);
    chk("rst_cfg_tvalid", {31'd0, cfg_tvalid_out}, 32'd0);
    chk("rst_tvalid", {31'd0, data_tvalid_out}, 32'd0);
    chk("rst_tdata", data_tdata_out, 32'd0);
    chk("rst_tlast", {31'd0, data_tlast_out}, 32'd0);
    chk("rst_busy", {31'd0, busy_out}, 32'd0);
    chk("rst_overrun", {31'd0, overrun_out}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count_out}, 32'd0);

    // Config with 5 cycles of backpressure.
    enable_in  = 1'b1;
    tick();
    cfg_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (cfg_tvalid_out) cfg_cycles++;
      tick();
    end
    cfg_tready_in = 1'b1;
    if (cfg_tvalid_out) cfg_cycles++;
    tick();
    cfg_tready_in = 1'b0;
    chk("cfg_valid_cycles", 32'(cfg_cycles), 32'd6);
    chk("cfg_valid_after_hs", {31'd0, cfg_tvalid_out}, 32'd0);
    chk("cfg_hs_count", 32'(cfg_hs_seen), 32'd1);
    chk("busy_in_fill", {31'd0, busy_out}, 32'd1);

    // Frame 1: sparse strobes, FFT always ready.
    data_tready_in = 1'b1;
    for (int k = 0; k < 512; k++) begin
      strobe(sv(k, 3), 1'b1);
      if (k == 0) chk("latency_tvalid", {31'd0, data_tvalid_out}, 32'd1);
      repeat (31) tick();
    end
    drain_wait("f1_drain");
    chk("f1_frame_count", {16'd0, frame_count_out}, 32'd1);
    chk("f1_beats", 32'(beats_seen), 32'd512);
    chk("f1_lasts", 32'(lasts_seen), 32'd1);
    chk("f1_busy_wait", {31'd0, busy_out}, 32'd1);
    strobe(8'h55, 1'b0);
    repeat (3) tick();
    chk("wait_strobe_ignored", 32'(beats_seen), 32'd512);
    chk("wait_no_overrun", {31'd0, overrun_out}, 32'd0);
    result_hs_in = 1'b1;
    tick();
    result_hs_in = 1'b0;
    chk("wait_needs_last", {31'd0, busy_out}, 32'd1);
    result_done();

    // Frame 2: back-to-back strobes (load and drain together), then backpressure.
    for (int k = 0; k < 10; k++) strobe(sv(k, 11), 1'b1);
    drain_wait("b2b_drain");
    chk("b2b_beats", 32'(beats_seen), 32'd522);
    chk("b2b_no_overrun", {31'd0, overrun_out}, 32'd0);
    data_tready_in = 1'b0;
    strobe(sv(10, 11), 1'b1);
    repeat (31) tick();
    strobe(8'hEE, 1'b0);
    repeat (7) tick();
    chk("bp_tvalid_held", {31'd0, data_tvalid_out}, 32'd1);
    chk("bp_tdata_held", data_tdata_out, {sv(10, 11), 24'h0});
    chk("bp_overrun", {31'd0, overrun_out}, 32'd1);
    chk("bp_no_beats", 32'(beats_seen), 32'd522);
    data_tready_in = 1'b1;
    drain_wait("bp_drain");
    chk("bp_beat_count", 32'(beats_seen), 32'd523);
    for (int k = 11; k < 512; k++) begin
      strobe(sv(k, 11), 1'b1);
      tick();
    end
    drain_wait("f2_drain");
    chk("f2_frame_count", {16'd0, frame_count_out}, 32'd2);
    result_done();

    // Frame 3: enable drops after beat 100; frame still completes.
    for (int k = 0; k < 512; k++) begin
      if (k == 100) enable_in = 1'b0;
      if (k == 50) result_done();
      strobe(sv(k, 29), 1'b1);
      tick();
    end
    drain_wait("f3_drain");
    chk("f3_frame_count", {16'd0, frame_count_out}, 32'd3);
    chk("f3_busy_wait", {31'd0, busy_out}, 32'd1);
    result_done();
    chk("f3_idle_busy", {31'd0, busy_out}, 32'd0);
    strobe(8'h77, 1'b0);
    repeat (3) tick();
    chk("idle_strobe_ignored", 32'(beats_seen), 32'd1536);
    chk("idle_cfg_tvalid", {31'd0, cfg_tvalid_out}, 32'd0);

    // Frame 4: re-enable, then asynchronous reset mid-frame at beat 300.
    enable_in     = 1'b1;
    cfg_tready_in = 1'b1;
    tick();
    tick();
    cfg_tready_in = 1'b0;
    chk("reconfig_hs_count", 32'(cfg_hs_seen), 32'd2);
    for (int k = 0; k < 300; k++) begin
      strobe(sv(k, 41), 1'b1);
      tick();
    end
    drain_wait("f4_drain");
    data_tready_in = 1'b0;
    strobe(8'h99, 1'b0);
    #2;
    rst_in = 1'b1;
    #1;
    chk("async_rst_tvalid", {31'd0, data_tvalid_out}, 32'd0);
    chk("async_rst_tdata", data_tdata_out, 32'd0);
    chk("async_rst_busy", {31'd0, busy_out}, 32'd0);
    chk("async_rst_overrun", {31'd0, overrun_out}, 32'd0);
    chk("async_rst_frame_count", {16'd0, frame_count_out}, 32'd0);
    exp_idx = 0;
    tick();
    rst_in         = 1'b0;
    data_tready_in = 1'b1;
    cfg_tready_in  = 1'b1;
    tick();
    tick();
    cfg_tready_in = 1'b0;
    chk("post_rst_cfg_hs", 32'(cfg_hs_seen), 32'd3);

    // Frame 5: tlast must land on beat 512 of the new frame.
    for (int k = 0; k < 512; k++) begin
      if (k == 511) chk("f5_no_early_last", 32'(lasts_seen), 32'd3);
      strobe(sv(k, 53), 1'b1);
      tick();
    end
    drain_wait("f5_drain");
    chk("f5_lasts", 32'(lasts_seen), 32'd4);
    chk("f5_frame_count", {16'd0, frame_count_out}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
